// File: rtl/mult_hilo_ctrl_if.sv
// Bundle between the EX-stage HI/LO controller, the pipeline, and the Booth multiplier.
// slave = controller side; master = pipeline plus multiplier side.
interface mult_hilo_ctrl_if #(
   parameter int DW = 32,
   parameter int MW = 16
);
   logic            op_valid;
   logic [2:0]      op;
   logic [DW-1:0]   rs_val;
   logic [DW-1:0]   rt_val;
   logic            stall;
   logic [DW-1:0]   rd_data;
   logic [MW-1:0]   mul_a;
   logic [MW-1:0]   mul_b;
   logic            mul_start;
   logic            mul_ready;
   logic [2*MW-1:0] mul_result;
   logic            busy;
   logic            err;

   modport slave (
      input  op_valid, op, rs_val, rt_val, mul_ready, mul_result,
      output stall, rd_data, mul_a, mul_b, mul_start, busy, err
   );

   modport master (
      output op_valid, op, rs_val, rt_val, mul_ready, mul_result,
      input  stall, rd_data, mul_a, mul_b, mul_start, busy, err
   );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// EX-stage HI/LO controller: launches the Booth multiplier, captures its product into HI/LO,
// serves MFHI/MFLO/MTHI/MTLO and stalls HI/LO-dependent ops while a multiply is in flight.
module mult_hilo_ctrl #(
   parameter int DW      = 32,
   parameter int MW      = 16,
   parameter int TIMEOUT = 64
) (
   input logic            clk,
   input logic            rst_n,
   mult_hilo_ctrl_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   localparam logic [2:0] OP_MULT = 3'b000;
   localparam logic [2:0] OP_MFHI = 3'b001;
   localparam logic [2:0] OP_MFLO = 3'b010;
   localparam logic [2:0] OP_MTHI = 3'b011;
   localparam logic [2:0] OP_MTLO = 3'b100;

   logic [0:0]    state_q, state_d;
   logic [DW-1:0] hi_q, hi_d;
   logic [DW-1:0] lo_q, lo_d;
   logic [MW-1:0] mul_a_q, mul_a_d;
   logic [MW-1:0] mul_b_q, mul_b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic          err_q, err_d;

   logic          in_busy;
   logic          hilo_op;
   logic          stall;
   logic          accept;
   logic          capture;
   logic          expired;
   logic [DW-1:0] rd_data;

   // Operand bits above MW are deliberately dropped.
   logic unused_operand_bits;
   assign unused_operand_bits = ^{bus.rs_val[DW-1:MW], bus.rt_val[DW-1:MW]};

   assign in_busy = (state_q == ST_BUSY);
   assign hilo_op = bus.op_valid && (bus.op <= OP_MTLO);
   assign stall   = hilo_op && in_busy;
   assign accept  = bus.op_valid && !stall;
   // Only a fresh rising edge of ready counts, so a level left high from before is ignored.
   assign capture = in_busy && bus.mul_ready && !ready_q;
   assign expired = (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      cnt_d   = cnt_q;
      ready_d = bus.mul_ready;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_MULT: begin
                     mul_a_d = bus.rs_val[MW-1:0];
                     mul_b_d = bus.rt_val[MW-1:0];
                     cnt_d   = '0;
                     state_d = ST_BUSY;
                  end
                  OP_MTHI: hi_d = bus.rs_val;
                  OP_MTLO: lo_d = bus.rs_val;
                  default: ;
               endcase
            end
         end
         default: begin
            cnt_d = cnt_q + CW'(1);
            // Capture has priority over a timeout on the same edge.
            if (capture) begin
               lo_d    = DW'($signed(bus.mul_result));
               hi_d    = {DW{bus.mul_result[2*MW-1]}};
               state_d = ST_IDLE;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      rd_data = '0;
      if (accept && bus.op == OP_MFHI) begin
         rd_data = hi_q;
      end else if (accept && bus.op == OP_MFLO) begin
         rd_data = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         err_q   <= err_d;
      end
   end

   assign bus.stall     = stall;
   assign bus.rd_data   = rd_data;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.mul_start = in_busy;
   assign bus.busy      = in_busy;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Directed bench for mult_hilo_ctrl: an architectural HI/LO model checked every cycle,
// a latency-programmable multiplier stand-in, and hand-computed literal expectations.
module tb_mult_hilo_ctrl;
   localparam int DW = 32;
   localparam int MW = 16;
   localparam int TIMEOUT = 64;
   localparam int LAT = 17;

   localparam logic [2:0] MULT = 3'd0;
   localparam logic [2:0] MFHI = 3'd1;
   localparam logic [2:0] MFLO = 3'd2;
   localparam logic [2:0] MTHI = 3'd3;
   localparam logic [2:0] MTLO = 3'd4;
   localparam logic [2:0] NOP  = 3'd5;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   mult_hilo_ctrl_if #(.DW(DW), .MW(MW)) bus ();

   mult_hilo_ctrl #(.DW(DW), .MW(MW), .TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Multiplier stand-in: ready pulses in the LAT-th cycle of start, or is tied/pulsed by hand.
   logic auto_en, tie_high, pulse_r, manual_pulse;
   int   ready_cnt;
   assign bus.mul_ready  = tie_high | pulse_r | manual_pulse;
   assign bus.mul_result = $signed({{16{bus.mul_a[15]}}, bus.mul_a}) *
                           $signed({{16{bus.mul_b[15]}}, bus.mul_b});

   always @(posedge clk) begin
      #1;
      if (auto_en && bus.mul_start) begin
         ready_cnt++;
         pulse_r = (ready_cnt == LAT);
      end else begin
         ready_cnt = 0;
         pulse_r   = 1'b0;
      end
   end

   // Architectural model: HI/LO, sticky error, in-flight multiply and its elapsed cycles.
   logic [31:0] m_hi, m_lo;
   logic [15:0] m_a, m_b;
   bit          m_busy, m_err, m_rprev;
   int          m_cyc;

   always @(negedge clk) begin
      bit          dep, acc;
      logic [31:0] exp_rd;
      int          prod;
      if (!rst_n) begin
         m_hi = 0; m_lo = 0; m_a = 0; m_b = 0;
         m_busy = 0; m_err = 0; m_rprev = 0; m_cyc = 0;
      end
      dep    = bus.op_valid && (bus.op <= MTLO) && m_busy;
      acc    = bus.op_valid && !dep;
      exp_rd = (acc && bus.op == MFHI) ? m_hi : (acc && bus.op == MFLO) ? m_lo : 32'd0;
      chk("stall",     {31'd0, bus.stall},     {31'd0, dep});
      chk("busy",      {31'd0, bus.busy},      {31'd0, m_busy});
      chk("mul_start", {31'd0, bus.mul_start}, {31'd0, m_busy});
      chk("err",       {31'd0, bus.err},       {31'd0, m_err});
      chk("rd_data",   bus.rd_data,            exp_rd);
      chk("mul_a",     {16'd0, bus.mul_a},     {16'd0, m_a});
      chk("mul_b",     {16'd0, bus.mul_b},     {16'd0, m_b});
      if (rst_n) begin
         if (m_busy) begin
            m_cyc++;
            if (bus.mul_ready && !m_rprev) begin
               prod   = int'($signed(m_a)) * int'($signed(m_b));
               m_lo   = prod;
               m_hi   = (prod < 0) ? 32'hFFFF_FFFF : 32'd0;
               m_busy = 0;
            end else if (m_cyc == TIMEOUT) begin
               m_err  = 1;
               m_busy = 0;
            end
         end else if (acc) begin
            case (bus.op)
               MULT: begin
                  m_a = bus.rs_val[15:0];
                  m_b = bus.rt_val[15:0];
                  m_busy = 1;
                  m_cyc = 0;
               end
               MTHI: m_hi = bus.rs_val;
               MTLO: m_lo = bus.rs_val;
               default: ;
            endcase
         end
         m_rprev = bus.mul_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents an op until accepted; returns rd_data of the accepting cycle and stall count.
   task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rd, output int stalls);
      bit done;
      stalls = 0;
      done = 0;
      rd = '0;
      bus.op_valid = 1'b1;
      bus.op = o;
      bus.rs_val = a;
      bus.rt_val = b;
      for (int n = 0; n < 200 && !done; n++) begin
         #2;
         if (!bus.stall) begin
            rd = bus.rd_data;
            done = 1;
         end else begin
            stalls++;
         end
         tick();
      end
      bus.op_valid = 1'b0;
      bus.op = NOP;
      if (!done) chk("op_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle(output int cyc);
      bit done;
      cyc = 0;
      done = 0;
      for (int n = 0; n < 200 && !done; n++) begin
         #1;
         if (bus.busy) cyc++;
         else done = 1;
         tick();
      end
      if (!done) chk("busy_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      int          st;
      int          cyc;
      checks = 0;
      failures = 0;
      auto_en = 1'b1;
      tie_high = 1'b0;
      manual_pulse = 1'b0;
      bus.op_valid = 1'b0;
      bus.op = NOP;
      bus.rs_val = '0;
      bus.rt_val = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      tick();
      tick();
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_start", {31'd0, bus.mul_start}, 32'd0);
      chk("reset_err", {31'd0, bus.err}, 32'd0);
      rst_n = 1'b1;
      tick();

      // 4 * 7 with a 17-cycle multiplier
      do_op(MULT, 32'd4, 32'd7, rd, st);
      chk("t1_mul_a", {16'd0, bus.mul_a}, 32'd4);
      chk("t1_mul_b", {16'd0, bus.mul_b}, 32'd7);
      wait_idle(cyc);
      chk("t1_busy_cycles", cyc, 32'd17);
      do_op(MFLO, 0, 0, rd, st);
      chk("t1_mflo", rd, 32'h0000_001C);
      do_op(MFHI, 0, 0, rd, st);
      chk("t1_mfhi", rd, 32'h0000_0000);

      // 1 * -1, dependent MFHI issued right behind it
      do_op(MULT, 32'd1, 32'h0000_FFFF, rd, st);
      do_op(MFHI, 0, 0, rd, st);
      chk("t2_stall_cycles", st, 32'd17);
      chk("t2_mfhi", rd, 32'hFFFF_FFFF);
      do_op(MFLO, 0, 0, rd, st);
      chk("t2_mflo", rd, 32'hFFFF_FFFF);

      // -10 * -1 queued behind 4 * 7
      do_op(MULT, 32'd4, 32'd7, rd, st);
      do_op(MULT, 32'hFFFF_FFF6, 32'h0000_FFFF, rd, st);
      chk("t3_second_mult_stalls", st, 32'd17);
      wait_idle(cyc);
      chk("t3_busy_cycles", cyc, 32'd17);
      do_op(MFLO, 0, 0, rd, st);
      chk("t3_mflo", rd, 32'h0000_000A);
      do_op(MFHI, 0, 0, rd, st);
      chk("t3_mfhi", rd, 32'h0000_0000);

      // MTHI then MFHI; NOP and MTLO during a multiply
      do_op(MTHI, 32'h1234_5678, 0, rd, st);
      chk("t4_mthi_stalls", st, 32'd0);
      do_op(MFHI, 0, 0, rd, st);
      chk("t4_mfhi", rd, 32'h1234_5678);
      chk("t4_mfhi_stalls", st, 32'd0);
      do_op(MULT, 32'd2, 32'd3, rd, st);
      do_op(NOP, 0, 0, rd, st);
      chk("t4_nop_stalls", st, 32'd0);
      do_op(MTLO, 32'h0000_0055, 0, rd, st);
      chk("t4_mtlo_stalls", st, 32'd16);
      do_op(MFLO, 0, 0, rd, st);
      chk("t4_mflo", rd, 32'h0000_0055);
      do_op(MFHI, 0, 0, rd, st);
      chk("t4_mfhi_after", rd, 32'h0000_0000);

      // ready held high across the whole multiply: must time out
      do_op(MTHI, 32'hAAAA_0000, 0, rd, st);
      do_op(MTLO, 32'h0000_BBBB, 0, rd, st);
      auto_en = 1'b0;
      tie_high = 1'b1;
      tick();
      tick();
      do_op(MULT, 32'd5, 32'd5, rd, st);
      wait_idle(cyc);
      chk("t5_busy_cycles", cyc, 32'd64);
      chk("t5_err", {31'd0, bus.err}, 32'd1);
      tie_high = 1'b0;
      auto_en = 1'b1;
      tick();
      do_op(MFHI, 0, 0, rd, st);
      chk("t5_mfhi", rd, 32'hAAAA_0000);
      do_op(MFLO, 0, 0, rd, st);
      chk("t5_mflo", rd, 32'h0000_BBBB);
      chk("t5_err_sticky", {31'd0, bus.err}, 32'd1);

      // asynchronous reset in the middle of a multiply
      do_op(MTHI, 32'h0000_0777, 0, rd, st);
      do_op(MULT, 32'd3, 32'd3, rd, st);
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("t6_busy", {31'd0, bus.busy}, 32'd0);
      chk("t6_start", {31'd0, bus.mul_start}, 32'd0);
      chk("t6_err", {31'd0, bus.err}, 32'd0);
      chk("t6_hi", dut.hi_q, 32'd0);
      chk("t6_lo", dut.lo_q, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      manual_pulse = 1'b1;
      tick();
      manual_pulse = 1'b0;
      tick();
      chk("t6_busy_after_pulse", {31'd0, bus.busy}, 32'd0);
      do_op(MFLO, 0, 0, rd, st);
      chk("t6_mflo", rd, 32'd0);
      do_op(MFHI, 0, 0, rd, st);
      chk("t6_mfhi", rd, 32'd0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- EX-stage controller between the pipeline and the 16-bit Booth multiplier.
- Accepts MULT/MFHI/MFLO/MTHI/MTLO ops and launches the multiplier over its start/ready handshake.
- Captures the 32-bit product into the architectural HI/LO registers.
- Stalls the pipeline while a multiply is in flight and a dependent HI/LO op is presented.

Parameters:
- DW, 32, pipeline data width (HI, LO, operands, read data).
- MW, 16, multiplier operand width; product is 2*MW.
- TIMEOUT, 64, max cycles in BUSY before abort.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  op presented this cycle.
- op  in  3  000 MULT, 001 MFHI, 010 MFLO, 011 MTHI, 100 MTLO; others are NOP.
- rs_val  in  DW  first operand / MTHI/MTLO data.
- rt_val  in  DW  second operand.
- stall  out  1  hold the pipeline; op not accepted this cycle.
- rd_data  out  DW  MFHI/MFLO result, valid when op_valid & !stall.
- mul_a  out  MW  multiplier operand a (registered).
- mul_b  out  MW  multiplier operand b (registered).
- mul_start  out  1  multiplier start, held high for the whole of BUSY.
- mul_ready  in  1  multiplier done.
- mul_result  in  2*MW  signed product.
- busy  out  1  multiply in flight.
- err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; hi=lo=0; mul_a=mul_b=0.
  - mul_start=0, busy=0, err=0, stall=0; timeout counter=0; ready_q=0.
  - Reset mid-multiply discards the product and leaves HI/LO at 0.
- FSM states: IDLE, BUSY.
- IDLE, accepting MULT (op_valid & op=000):
  - Latch mul_a=rs_val[MW-1:0] and mul_b=rt_val[MW-1:0] (two's complement).
  - Clear the counter; go to BUSY.
  - mul_start is 1 from the next cycle.
- BUSY:
  - mul_start=1, busy=1; counter increments each cycle.
  - ready_q registers mul_ready every cycle in all states.
- BUSY, capture:
  - Condition: rising edge, mul_ready=1 & ready_q=0.
  - At that edge: lo = sign-extend(mul_result) to DW; hi = {DW{mul_result[2*MW-1]}}.
  - Go to IDLE; mul_start drops the following cycle.
  - A mul_ready already high on BUSY entry is ignored until it falls and rises again.
- BUSY, timeout:
  - Condition: counter reaches TIMEOUT-1 with no capture.
  - Go to IDLE; set err=1 (sticky until reset); HI/LO unchanged.
  - Capture wins if it occurs on the same edge.
- stall (combinational) = op_valid & busy & op in {MULT, MFHI, MFLO, MTHI, MTLO}.
  - NOP ops never stall.
  - stall falls in the first cycle state is IDLE after capture; the stalled op is accepted that cycle and sees the new HI/LO.
- MFHI/MFLO (accepted): rd_data = hi or lo combinationally the same cycle; otherwise rd_data=0.
- MTHI/MTLO (accepted): hi or lo = rs_val at the clock edge; a following MFHI/MFLO sees the new value next cycle.
- Back-to-back MULT: a second MULT presented during BUSY stalls. It is accepted the cycle after capture and re-enters BUSY with new operands.
- Operand truncation: bits above MW are ignored; no overflow flag.

Test Plan:
- Reset, rs=4, rt=7, MULT; model multiplier asserts ready after 17 cycles. Required:
  - mul_a=4, mul_b=7.
  - busy for 17 cycles.
  - then lo=0x0000001C, hi=0x00000000.
  - MFLO returns 0x1C.
- MULT 1*-1 (rt=0x0000FFFF), MFHI issued the cycle after MULT. Required:
  - stall=1 until the capture edge.
  - then rd_data=0xFFFFFFFF.
  - lo=0xFFFFFFFF.
- MULT -10*-1 back-to-back behind a pending MULT 4*7. Required:
  - the second MULT stalls and is accepted the cycle after the first capture.
  - final lo=0x0000000A, hi=0.
- MTHI 0x12345678 then MFHI next cycle. Required:
  - rd_data=0x12345678, no stall.
  - MTLO during BUSY stalls.
- mul_ready tied high before MULT, never toggling, TIMEOUT=64. Required:
  - no capture.
  - IDLE after 64 BUSY cycles, err=1.
  - HI/LO unchanged.
- rst_n pulsed low mid-BUSY. Required:
  - mul_start=0, busy=0, hi=lo=0 immediately (asynchronously).
  - a later ready pulse is ignored.
